// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 <-> int32 converter.
// Contents: operation and FSM state enums, binary32/int32 format constants,
// and the bit positions of the {invalid, inexact} flag pair.
package fp_pkg;

    typedef enum logic {
        CONV_I2F = 1'b0,
        CONV_F2I = 1'b1
    } conv_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    localparam logic [7:0]  FP_BIAS    = 8'd127;
    localparam logic [7:0]  FP_EXP_I32 = 8'd158;  // exponent of 2^31
    localparam logic [7:0]  FP_EXP_MAX = 8'd255;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;

    localparam int FLAG_INVALID = 1;
    localparam int FLAG_INEXACT = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even packer for a normalised 32-bit magnitude.
// Ports:
//   sign_i     sign of the result
//   exp_i      biased exponent belonging to mag_i[31] (9 bits)
//   mag_i      normalised magnitude, mag_i[31] must be 1
//   result_o   packed binary32 {sign, exp, frac}
//   inexact_o  any discarded bit was non-zero
module fp_round_rne (
    input  logic        sign_i,
    input  logic [8:0]  exp_i,
    input  logic [31:0] mag_i,
    output logic [31:0] result_o,
    output logic        inexact_o
);

    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [24:0] sig_sum;
    logic [8:0]  exp_adj;
    logic [22:0] frac;
    logic        unused_exp_msb;

    always_comb begin
        guard    = mag_i[7];
        sticky   = |mag_i[6:0];
        round_up = guard & (sticky | mag_i[8]);
        sig_sum  = {1'b0, mag_i[31:8]} + {24'd0, round_up};
        // Carry out of the significand: value became 2.0, so frac wraps to 0.
        exp_adj  = exp_i + {8'd0, sig_sum[24]};
        frac     = sig_sum[24] ? 23'd0 : sig_sum[22:0];
        result_o  = {sign_i, exp_adj[7:0], frac};
        inexact_o = guard | sticky;
    end

    // Exponent never exceeds 8 bits for int32 inputs.
    assign unused_exp_msb = exp_adj[8];

endmodule

// File: rtl/fp_int_convert.sv
// Multi-cycle converter between binary32 and signed int32 using a
// one-bit-per-cycle normalise/denormalise shifter.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   in_op                 0 = int->float, 1 = float->int (truncate)
//   in_data               operand
//   out_valid/out_ready   result handshake
//   out_data              result
//   out_flags             {invalid, inexact}
//
// state | meaning
// IDLE  | waiting for a request
// SHIFT | normalise (i2f, left) or denormalise (f2i, right), one bit/cycle
// ROUND | pack/round (i2f) or apply sign (f2i) into the output registers
// DONE  | result held until out_ready
module fp_int_convert
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flags
);

    conv_state_e state_q, state_d;
    conv_op_e    op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [8:0]  exp_q, exp_d;
    logic [4:0]  count_q, count_d;
    logic        sticky_q, sticky_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_flags_q, out_flags_d;

    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [7:0]  shift_amt;
    logic [31:0] rnd_result;
    logic        rnd_inexact;

    assign in_exp    = in_data[30:23];
    assign in_frac   = in_data[22:0];
    assign shift_amt = FP_EXP_I32 - in_exp;

    fp_round_rne u_round (
        .sign_i    (sign_q),
        .exp_i     (exp_q),
        .mag_i     (mag_q),
        .result_o  (rnd_result),
        .inexact_o (rnd_inexact)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = conv_op_e'(in_op);
                    sign_d   = in_data[31];
                    sticky_d = 1'b0;
                    count_d  = 5'd0;
                    exp_d    = 9'd0;
                    mag_d    = 32'd0;
                    if (conv_op_e'(in_op) == CONV_I2F) begin
                        if (in_data == 32'd0) begin
                            out_data_d  = 32'd0;
                            out_flags_d = 2'b00;
                            state_d     = DONE;
                        end else begin
                            // -2^31 negates to itself, which is the right magnitude.
                            mag_d   = in_data[31] ? (~in_data + 32'd1) : in_data;
                            exp_d   = {1'b0, FP_EXP_I32};
                            state_d = SHIFT;
                        end
                    end else begin
                        out_flags_d = 2'b00;
                        if (in_exp == FP_EXP_MAX && in_frac != 23'd0) begin
                            out_data_d                = INT32_MAX;
                            out_flags_d[FLAG_INVALID] = 1'b1;
                            state_d                   = DONE;
                        end else if (in_exp < FP_BIAS) begin
                            out_data_d                = 32'd0;
                            out_flags_d[FLAG_INEXACT] = |in_data[30:0];
                            state_d                   = DONE;
                        end else if (in_exp >= FP_EXP_I32) begin
                            out_data_d = in_data[31] ? INT32_MIN : INT32_MAX;
                            // -2^31 exactly is representable.
                            out_flags_d[FLAG_INVALID] =
                                !(in_data[31] && in_exp == FP_EXP_I32 && in_frac == 23'd0);
                            state_d = DONE;
                        end else begin
                            mag_d   = {1'b1, in_frac, 8'd0};
                            count_d = shift_amt[4:0];
                            state_d = SHIFT;
                        end
                    end
                end
            end

            SHIFT: begin
                if (op_q == CONV_I2F) begin
                    if (mag_q[31]) begin
                        state_d = ROUND;
                    end else begin
                        mag_d = {mag_q[30:0], 1'b0};
                        exp_d = exp_q - 9'd1;
                    end
                end else begin
                    if (count_q == 5'd0) begin
                        state_d = ROUND;
                    end else begin
                        mag_d    = {1'b0, mag_q[31:1]};
                        sticky_d = sticky_q | mag_q[0];
                        count_d  = count_q - 5'd1;
                    end
                end
            end

            ROUND: begin
                out_flags_d = 2'b00;
                if (op_q == CONV_I2F) begin
                    out_data_d                = rnd_result;
                    out_flags_d[FLAG_INEXACT] = rnd_inexact;
                end else begin
                    out_data_d                = sign_q ? (~mag_q + 32'd1) : mag_q;
                    out_flags_d[FLAG_INEXACT] = sticky_q;
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= CONV_I2F;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            exp_q       <= 9'd0;
            count_q     <= 5'd0;
            sticky_q    <= 1'b0;
            out_data_q  <= 32'd0;
            out_flags_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: doc/fp_int_convert.md
Name: fp_int_convert

Overview:
- Multi-cycle converter between IEEE-754 binary32 and signed 32-bit integers.
- Sits beside the floating-point ALU on the execute path. It produces float operands from integer registers (int->float) and returns float results to the integer side (float->int).
- Uses a valid/ready request–response handshake.
- Normalisation and denormalisation use a one-bit-per-cycle shifter, trading latency for area.

Parameters:
- none. Format is fixed at binary32 / int32.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (high only in IDLE).
- in_op  in  1  0 = int->float (signed), 1 = float->int (signed, truncate toward zero).
- in_data  in  32  int32 operand (op 0) or binary32 operand (op 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  binary32 result (op 0) or int32 result (op 1).
- out_flags  out  2  {invalid, inexact}.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0, internal regs=0. Reset asserted mid-operation aborts it; no result is ever emitted for that request.
- States: IDLE, SHIFT, ROUND, DONE.
- Accept: handshake when in_valid & in_ready at edge T. Capture op, sign, magnitude/shift count.
- Back-pressure: in_ready is low in SHIFT, ROUND and DONE. There is no accept in the same cycle as a result is consumed, giving a one-cycle bubble by design.
- Output: DONE holds out_valid=1, with out_data/out_flags stable until out_valid & out_ready; it then returns to IDLE.
- int->float (op 0):
  - in_data==0: go directly to DONE. Result 0x00000000, flags 00, out_valid in cycle T+1.
  - Otherwise: sign=in_data[31], mag=|in_data| as 32-bit unsigned (-2^31 gives 0x80000000), exp=158.
  - SHIFT: while mag[31]==0, mag<<=1 and exp-=1 (one per cycle). When mag[31]==1, go to ROUND.
  - ROUND: frac=mag[30:8], guard=mag[7], sticky=|mag[6:0]. Round-to-nearest-even: up = guard & (sticky | mag[8]).
  - Carry out of {1,frac}+up sets frac=0 and exp+=1.
  - Result = {sign, exp, frac}. inexact = guard|sticky; invalid=0.
  - Latency: with lz = leading zeros of mag, out_valid first high in cycle T+3+lz (range T+3..T+34).
- float->int (op 1): with e=in_data[30:23] and f=in_data[22:0]:
  - e==255 & f!=0 (NaN): result 0x7FFFFFFF, invalid=1.
  - e<127 (zero, subnormal, |x|<1): result 0, inexact = (e!=0 | f!=0). Goes directly to DONE at T+1.
  - e>=158: result is sign ? 0x80000000 : 0x7FFFFFFF. invalid=1 except the exact case sign=1, e=158, f=0 (result 0x80000000, flags 00). Goes directly to DONE at T+1.
  - Otherwise: mag={1,f,8'b0}, count=158-e (1..31).
    - SHIFT: mag>>=1 per cycle, OR each shifted-out bit into sticky, count-=1. count==0 moves to ROUND.
    - ROUND: result = sign ? -mag : mag (two's complement, 32-bit). inexact=sticky; invalid=0.
    - Latency: out_valid at T+3+count.
- Arithmetic: exponent is held in 9 bits internally; it never goes below 127 for op 0.
- Flags are registered alongside out_data.

Decomposition:
- Shared package fp_pkg holds:
  - conv_op_e {CONV_I2F, CONV_F2I}
  - conv_state_e {IDLE, SHIFT, ROUND, DONE}
  - constants FP_BIAS=127, FP_EXP_I32=158, FP_EXP_MAX=255, INT32_MIN=32'h80000000, INT32_MAX=32'h7FFFFFFF
  - flag bit indices FLAG_INVALID=1, FLAG_INEXACT=0
- One combinational sub-module, fp_round_rne: inputs {sign, exp[8:0], mag[31:0]}, outputs {packed result, inexact}. It can be reused by the ALU later.

Test Plan:
- i2f: in_data=0x00000001 -> out_data=0x3F800000, flags 00, out_valid at T+34. in_data=0x80000000 -> 0xCF000000, flags 00, at T+3.
- i2f RNE: 0x01000001 -> 0x4B800000 (tie, even, down), inexact=1. 0x01000003 -> 0x4B800002 (tie, up), inexact=1. 0xFFFFFFFF -> 0xBF800000, flags 00.
- f2i: 0xC0300000 (-2.75) -> 0xFFFFFFFE, inexact=1, at T+33. 0x3F000000 (0.5) -> 0, inexact=1, at T+1.
- f2i saturation:
  - 0x4F32D05E (3e9) -> 0x7FFFFFFF, invalid=1.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid=1.
  - 0xFF800000 (-Inf) -> 0x80000000, invalid=1.
  - 0xCF000000 -> 0x80000000, flags 00.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, a queued in_valid is not accepted. After out_ready pulse, accept occurs in the next cycle only.
- Reset: assert rst_n=0 mid-SHIFT on an i2f of 0x00000001 -> outputs at reset values immediately. No out_valid afterwards. A next request (0x00000002) yields 0x40000000.
